// File: rtl/riscv_pkg.sv
// Shared core constants: instruction memory geometry, byte/word widths and the
// loader state encoding, also used by the fetch stage.
package riscv_pkg;
   localparam int IMEM_DEPTH     = 32;
   localparam int IMEM_ADDR_W    = $clog2(IMEM_DEPTH);
   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } loader_state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction memory loader.
interface imem_loader_if;
   import riscv_pkg::*;

   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted bytes little-endian into a 32-bit word and pulses
// word_valid on the cycle after the fourth byte of a word is taken.
module byte_packer
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              take,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [1:0]        byte_idx,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);
   // Bytes shift in from the top, so byte 0 ends up in bits [7:0] after four takes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_idx   <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= take && (byte_idx == 2'd3);
         if (clr) begin
            byte_idx <= '0;
         end else if (take) begin
            byte_idx <= byte_idx + 2'd1;
            word     <= {byte_in, word[WORD_W-1:BYTE_W]};
         end
      end
   end
endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream into words, writes them in order
// and holds the core in reset while loading. IMEM_LOADER_CHECKSUM_EN adds an XOR trailer check.
module imem_loader
   import riscv_pkg::*;
#(
   parameter  int DEPTH  = IMEM_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   imem_loader_if.slave      bs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

   loader_state_e     state, state_nxt;
   logic [ADDR_W:0]   len_q, wcnt_q;
   logic              last_taken_q, hold_q, err_q;
   logic              in_ready, take, take_payload, start_acc;
   logic              word_valid;
   logic [1:0]        byte_idx;
   logic [WORD_W-1:0] word;

   assign start_acc    = start && (state == S_IDLE || state == S_DONE);
   assign take         = bs.in_valid && in_ready;
   assign take_payload = take && (state == S_LOAD);

   byte_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (start_acc),
      .take       (take_payload),
      .byte_in    (bs.in_data),
      .byte_idx   (byte_idx),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = (len == '0 || len > MAX_LEN) ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            in_ready = !last_taken_q;
            if (word_valid && last_taken_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = S_CHECK;
`else
               state_nxt = S_DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            in_ready = 1'b1;
            if (bs.in_valid) state_nxt = S_DONE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          csum_q <= '0;
      else if (start_acc)    csum_q <= '0;
      else if (take_payload) csum_q <= csum_q ^ bs.in_data;
   end
`endif

   // Word counter, last-byte flag and the hold/err status that outlive the load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q        <= '0;
         wcnt_q       <= '0;
         last_taken_q <= 1'b0;
         hold_q       <= 1'b1;
         err_q        <= 1'b0;
      end else if (start_acc) begin
         len_q        <= len;
         wcnt_q       <= '0;
         last_taken_q <= 1'b0;
         hold_q       <= (len != '0);
         err_q        <= (len > MAX_LEN);
      end else begin
         if (take_payload && byte_idx == 2'd3 && (wcnt_q + ONE) == len_q)
            last_taken_q <= 1'b1;
         if (word_valid) begin
            wcnt_q <= wcnt_q + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
         end
         if (state == S_CHECK && take) begin
            err_q  <= (bs.in_data != csum_q);
            hold_q <= (bs.in_data != csum_q);
`else
            if (last_taken_q) hold_q <= 1'b0;
`endif
         end
      end
   end

   assign bs.in_ready = in_ready;
   assign mem_we      = word_valid;
   assign mem_waddr   = wcnt_q[ADDR_W-1:0];
   assign mem_wdata   = word;
   assign cpu_hold    = hold_q;
   assign err         = err_q;
   assign busy        = (state == S_LOAD) || (state == S_CHECK);
   assign done        = (state == S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued when bytes are
// prepared and popped as mem_we strobes appear.
`timescale 1ns/1ps
module tb_imem_loader;
   import riscv_pkg::*;

   localparam int DEPTH  = IMEM_DEPTH;
   localparam int ADDR_W = $clog2(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b0;
   logic              start   = 1'b0;
   logic [ADDR_W:0]   len     = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold, busy, done, err;

   imem_loader_if bs ();

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .len       (len),
      .bs        (bs),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wr_t         exp_q[$];
   logic [7:0]  tx_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_we = 0;
   int          last_we_cyc = -1;
   logic [31:0] last_wdata = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Write monitor: every strobe must match the head of the scoreboard.
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (reset_n && mem_we) begin
            n_we++;
            last_we_cyc = cyc;
            last_wdata  = mem_wdata;
            if (exp_q.size() == 0) begin
               chk("spurious_we", 32'(mem_we), 32'd0);
            end else begin
               w = exp_q.pop_front();
               chk("waddr", 32'(mem_waddr), 32'(w.a));
               chk("wdata", mem_wdata, w.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      len   = (ADDR_W+1)'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string p);
      chk({p, "_hold"},  32'(cpu_hold),    32'd1);
      chk({p, "_ready"}, 32'(bs.in_ready), 32'd0);
      chk({p, "_we"},    32'(mem_we),      32'd0);
      chk({p, "_waddr"}, 32'(mem_waddr),   32'd0);
      chk({p, "_wdata"}, mem_wdata,        32'd0);
      chk({p, "_busy"},  32'(busy),        32'd0);
      chk({p, "_done"},  32'(done),        32'd0);
      chk({p, "_err"},   32'(err),         32'd0);
   endtask

   task automatic push_expected(input int n, output logic [7:0] x);
      x = '0;
      for (int w = 0; w < n; w++) begin
         exp_q.push_back(wr_t'{ADDR_W'(w),
            {tx_q[4*w+3], tx_q[4*w+2], tx_q[4*w+1], tx_q[4*w]}});
         for (int b = 0; b < 4; b++) x = x ^ tx_q[4*w+b];
      end
   endtask

   task automatic stream(input bit toggle, input int budget);
      int k = 0;
      while (tx_q.size() > 0 && k < budget) begin
         bit acc;
         bs.in_valid = toggle ? (k[0] == 1'b0) : 1'b1;
         bs.in_data  = tx_q[0];
         acc = bs.in_valid && bs.in_ready;
         tick();
         k++;
         if (acc) void'(tx_q.pop_front());
      end
      bs.in_valid = 1'b0;
      if (tx_q.size() != 0) begin
         chk("stream_timeout", 32'(tx_q.size()), 32'd0);
         tx_q.delete();
      end
   endtask

   task automatic wait_done(output int at);
      int k = 0;
      while (!done && k < 400) begin
         tick();
         k++;
      end
      at = cyc;
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic run_load(input string p, input int n, input bit toggle, input bit bad_csum);
      int         c0, at, we0;
      logic [7:0] x;
      bit         exp_err;
      exp_err = bad_csum && (CK == 1);
      push_expected(n, x);
      we0 = n_we;
      c0  = cyc;
      do_start(n);
      chk({p, "_busy_start"},  32'(busy),        32'd1);
      chk({p, "_ready_start"}, 32'(bs.in_ready), 32'd1);
      stream(toggle, 40*n + 40);
`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q.push_back(bad_csum ? ~x : x);
      stream(1'b0, 20);
`endif
      wait_done(at);
      chk({p, "_done"},      32'(done),          32'd1);
      chk({p, "_busy_end"},  32'(busy),          32'd0);
      chk({p, "_err"},       32'(err),           32'(exp_err));
      chk({p, "_hold"},      32'(cpu_hold),      32'(exp_err));
      chk({p, "_nwrites"},   32'(n_we - we0),    32'(n));
      chk({p, "_sb_empty"},  32'(exp_q.size()),  32'd0);
      chk({p, "_done_cyc"},  32'(at),            32'(last_we_cyc + 1 + CK));
      if (!toggle) chk({p, "_latency"}, 32'(at - c0), 32'(4*n + 2 + CK));
   endtask

   initial begin
      int we0;
      bs.in_valid = 1'b0;
      bs.in_data  = '0;
      reset_n     = 1'b0;
      repeat (3) tick();
      check_reset_vals("rst");
      reset_n = 1'b1;
      tick();

      tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load("len2", 2, 1'b0, 1'b0);

      tx_q = '{8'hB7, 8'h12, 8'h34, 8'h56};
      run_load("toggle", 1, 1'b1, 1'b0);

      we0 = n_we;
      do_start(33);
      chk("len33_done", 32'(done),     32'd1);
      chk("len33_err",  32'(err),      32'd1);
      chk("len33_hold", 32'(cpu_hold), 32'd1);
      chk("len33_busy", 32'(busy),     32'd0);
      bs.in_valid = 1'b1;
      repeat (3) tick();
      chk("done_ready_idle", 32'(bs.in_ready), 32'd0);
      bs.in_valid = 1'b0;
      do_start(0);
      chk("len0_done", 32'(done),     32'd1);
      chk("len0_hold", 32'(cpu_hold), 32'd0);
      chk("len0_err",  32'(err),      32'd0);
      repeat (3) tick();
      chk("len_bad_nowrite", 32'(n_we - we0), 32'd0);

      do_start(4);
      exp_q.push_back(wr_t'{ADDR_W'(0), 32'h44332211});
      tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      stream(1'b0, 50);
      reset_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      tx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      run_load("after_rst", 1, 1'b0, 1'b0);

      for (int i = 0; i < 128; i++) tx_q.push_back(8'(i));
      run_load("len32", 32, 1'b0, 1'b0);
      chk("len32_last_word", last_wdata, 32'h7F7E7D7C);

`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load("csum_bad", 2, 1'b0, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
